// File: rtl/shifter_sched.sv
// shifter_sched: a single channel shifter time-multiplexed over R, G, B with per-channel config.
// Define SHIFTER_SCHED_SAT_EN to clamp each 10-bit output field to MAX_COLOR (255).
module shifter_sched #(
  parameter logic [3:0] RST_PARAM = 4'b0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_pix,
  input  logic        shift_en,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_ch,
  input  logic [3:0]  cfg_param,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [29:0] out_pix,
  output logic        busy
);
  localparam int unsigned CW  = 8;
  localparam int unsigned SW  = 10;
  localparam int unsigned PW  = 4;
  localparam int unsigned NCH = 3;

  typedef enum logic [2:0] {IDLE, CH_R, CH_G, CH_B, OUT} state_t;

  state_t                 state;
  logic [NCH-1:0][PW-1:0] act;
  logic [NCH-1:0][PW-1:0] snap;
  logic [23:0]            pix_q;
  logic                   en_q;
  logic                   pend_v;
  logic [1:0]             pend_ch;
  logic [PW-1:0]          pend_p;

  logic [CW-1:0] sh_in;
  logic [PW-1:0] sh_par;
  logic [SW-1:0] sh_ext;
  logic [SW-1:0] sh_out;
  logic [SW-1:0] res;

  // Steer the current channel and its snapshot parameter into the shared shifter
  always_comb begin
    sh_in  = pix_q[23:16];
    sh_par = snap[0];
    case (state)
      CH_G: begin
        sh_in  = pix_q[15:8];
        sh_par = snap[1];
      end
      CH_B: begin
        sh_in  = pix_q[7:0];
        sh_par = snap[2];
      end
      default: ;
    endcase
  end

  // The shared shifter: unsupported amounts pass through, ZERO/11 directions force 0
  always_comb begin
    sh_ext = SW'(sh_in);
    sh_out = sh_ext;
    if (en_q) begin
      case (sh_par[3:2])
        2'b01: if (sh_par[1:0] != 2'd0) sh_out = sh_ext >> sh_par[1:0];
        2'b10: if (sh_par[1:0] == 2'd1 || sh_par[1:0] == 2'd2) sh_out = sh_ext << sh_par[1:0];
        default: sh_out = '0;
      endcase
    end
  end

`ifdef SHIFTER_SCHED_SAT_EN
  localparam logic [SW-1:0] MAX_COLOR = SW'(255);
  assign res = (sh_out > MAX_COLOR) ? MAX_COLOR : sh_out;
`else
  assign res = sh_out;
`endif

  // Scheduler FSM, config registers, pending-write slot and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_pix   <= '0;
      pix_q     <= '0;
      en_q      <= 1'b0;
      pend_v    <= 1'b0;
      pend_ch   <= '0;
      pend_p    <= RST_PARAM;
      for (int i = 0; i < NCH; i++) begin
        act[i]  <= RST_PARAM;
        snap[i] <= RST_PARAM;
      end
    end else begin
      if (state != IDLE && cfg_we) begin
        pend_v  <= 1'b1;
        pend_ch <= cfg_ch;
        pend_p  <= cfg_param;
      end
      case (state)
        IDLE: begin
          for (int i = 0; i < NCH; i++)
            if (cfg_we && (cfg_ch == 2'd3 || cfg_ch == 2'(i))) act[i] <= cfg_param;
          if (in_valid) begin
            pix_q    <= in_pix;
            en_q     <= shift_en;
            snap     <= act;
            state    <= CH_R;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CH_R: begin
          out_pix[29:20] <= res;
          state          <= CH_G;
        end
        CH_G: begin
          out_pix[19:10] <= res;
          state          <= CH_B;
        end
        CH_B: begin
          out_pix[9:0] <= res;
          out_valid    <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            pend_v    <= 1'b0;
            // A write landing on the exit edge is the newest, so it overrides pending
            for (int i = 0; i < NCH; i++) begin
              if (pend_v && (pend_ch == 2'd3 || pend_ch == 2'(i))) act[i] <= pend_p;
              if (cfg_we && (cfg_ch == 2'd3 || cfg_ch == 2'(i))) act[i] <= cfg_param;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_sched.sv
// Directed self-checking bench for shifter_sched (honours SHIFTER_SCHED_SAT_EN for expectations).
module tb_shifter_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_pix;
  logic        shift_en;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [3:0]  cfg_param;
  logic        out_valid;
  logic        out_ready;
  logic [29:0] out_pix;
  logic        busy;

  int total = 0;
  int bad   = 0;

`ifdef SHIFTER_SCHED_SAT_EN
  localparam logic [29:0] E_LEFT2 = {10'h0FF, 10'h004, 10'h0FF};
`else
  localparam logic [29:0] E_LEFT2 = {10'h3FC, 10'h004, 10'h200};
`endif

  shifter_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .shift_en  (shift_en),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_param (cfg_param),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [3:0] p);
    cfg_we = 1'b1; cfg_ch = ch; cfg_param = p;
    tick();
    cfg_we = 1'b0;
  endtask

  // Starts in IDLE, returns with the DUT in OUT
  task automatic run_pix(input string tag, input logic [23:0] p, input logic en, input logic [29:0] e);
    in_valid = 1'b1; in_pix = p; shift_en = en;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    tick();
    tick();
    chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_pix"}, 32'(out_pix), 32'(e));
  endtask

  logic [29:0] held;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_pix = '0; shift_en = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_param = '0; out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_pix", 32'(out_pix), 32'd0);
    rst_n = 1'b1;
    tick();

    // Reset params pass pixels through
    run_pix("pass", 24'h8040FF, 1'b1, {10'h080, 10'h040, 10'h0FF});
    tick();
    chk("pass_back_idle", 32'(in_ready), 32'd1);

    // Broadcast LEFT by 2
    cfg(2'd3, 4'b1010);
    run_pix("left2", 24'hFF0180, 1'b1, E_LEFT2);
    tick();
    run_pix("bypass", 24'hFF0180, 1'b0, {10'h0FF, 10'h001, 10'h080});
    tick();

    // Mixed per-channel config, LEFT by 3 is out of range
    cfg(2'd0, 4'b0111);
    cfg(2'd1, 4'b0000);
    cfg(2'd2, 4'b1011);
    run_pix("mixed", 24'h887705, 1'b1, {10'h011, 10'h000, 10'h005});
    tick();

    // Write coincident with accept, then a pending write issued in CH_G
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_param = 4'b0101;
    in_valid = 1'b1; in_pix = 24'h887705; shift_en = 1'b1;
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    tick();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_param = 4'b0100;
    tick();
    cfg_we = 1'b0;
    tick();
    chk("snap_valid", 32'(out_valid), 32'd1);
    chk("snap_pix", 32'(out_pix), 32'({10'h011, 10'h000, 10'h005}));
    tick();
    run_pix("newcfg", 24'h887705, 1'b1, {10'h088, 10'h03B, 10'h005});
    tick();

    // Backpressure: hold OUT for 10 cycles while a new pixel waits
    out_ready = 1'b0;
    run_pix("hold", 24'h887705, 1'b1, {10'h088, 10'h03B, 10'h005});
    held = {10'h088, 10'h03B, 10'h005};
    in_valid = 1'b1; in_pix = 24'h102030; shift_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_pix", 32'(out_pix), 32'(held));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("next_accept_busy", 32'(busy), 32'd1);
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("next_pix", 32'(out_pix), 32'({10'h010, 10'h010, 10'h030}));
    tick();

    // Reset in CH_B with a pending write outstanding
    cfg(2'd3, 4'b1001);
    in_valid = 1'b1; in_pix = 24'h8040FF; shift_en = 1'b1;
    tick();
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_param = 4'b0000;
    tick();
    cfg_we = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out_pix", 32'(out_pix), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    run_pix("post_rst", 24'h8040FF, 1'b1, {10'h080, 10'h040, 10'h0FF});
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
